tc0480scp_rom_cache: RTL and testbench

//  Direct-mapped read cache between the TC0480SCP tile-gfx fetch port and the SDRAM ROM channel.
//  - Both sides use toggle req/ack handshakes. A transaction is outstanding while req != ack.
//  - Serves repeated 64-bit tile-row fetches, e.g. the same tile repeated across a line, without SDRAM traffic.
//  - Upstream of TC0480SCP rom_*; downstream of the SDRAM arbiter port.
//

---
 rtl/tc0480scp_rom_cache.sv | 178 +++++++++++++++++
 tb/tb_tc0480scp_rom_cache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc0480scp_rom_cache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tc0480scp_rom_cache
// Description : Direct-mapped read cache between the TC0480SCP tile-gfx fetch
//               port and the SDRAM ROM channel. Toggle req/ack on both sides.
//               Optional hit/miss statistics: TC0480SCP_ROM_CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tc0480scp_rom_cache #(
    parameter int LINE_BITS  = 6,
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cli_address_i,
    input  logic                  cli_req_i,
    output logic                  cli_ack_o,
    output logic [63:0]           cli_data_o,
    input  logic                  flush_i,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    input  logic [63:0]           mem_data_i
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o
`endif
);

    localparam int LINES    = 1 << LINE_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - LINE_BITS - 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:3]   addr_q;
    logic                    cli_ack_q;
    logic [63:0]             cli_data_q;
    logic [ADDR_WIDTH-1:0]   mem_address_q;
    logic                    mem_req_q;
    logic                    flushed_q;
    logic [LINES-1:0]        valid_q;

    logic [63:0]             data_ram [LINES];
    logic [TAG_BITS-1:0]     tag_ram  [LINES];
    logic [63:0]             rd_data_q;
    logic [TAG_BITS-1:0]     rd_tag_q;

    logic [LINE_BITS-1:0]    w_req_idx;
    logic [LINE_BITS-1:0]    w_idx;
    logic [TAG_BITS-1:0]     w_tag;
    logic                    w_hit;
    logic                    w_fill_done;
    logic                    w_fill_valid;
    logic                    w_unused_bits;

    // The low three address bits select a byte inside the 64-bit word only.
    assign w_unused_bits = ^cli_address_i[2:0];

    assign w_req_idx    = cli_address_i[LINE_BITS+2:3];
    assign w_idx        = addr_q[LINE_BITS+2:3];
    assign w_tag        = addr_q[ADDR_WIDTH-1:LINE_BITS+3];
    // A flush in the lookup cycle must not let stale data through.
    assign w_hit        = valid_q[w_idx] && (rd_tag_q == w_tag) && !flush_i;
    assign w_fill_done  = (state_q == S_FILL) && (mem_ack_i == mem_req_q);
    // Data fetched across a flush may predate the ROM reload: return it, don't keep it.
    assign w_fill_valid = w_fill_done && !flushed_q && !flush_i;

    assign cli_ack_o     = cli_ack_q;
    assign cli_data_o    = cli_data_q;
    assign mem_address_o = mem_address_q;
    assign mem_req_o     = mem_req_q;

    // Line storage: written on fill completion, read with one cycle latency while idle.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            data_ram[w_idx] <= mem_data_i;
            tag_ram[w_idx]  <= w_tag;
        end
        if (state_q == S_IDLE) begin
            rd_data_q <= data_ram[w_req_idx];
            rd_tag_q  <= tag_ram[w_req_idx];
        end
    end

    // Valid bits: flush clears all at once; a clean fill validates its line.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_q <= '0;
        end else if (w_fill_valid) begin
            valid_q[w_idx] <= 1'b1;
        end
    end

    // Control FSM with registered handshake and data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cli_ack_q     <= 1'b0;
            cli_data_q    <= '0;
            mem_address_q <= '0;
            mem_req_q     <= 1'b0;
            flushed_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cli_req_i != cli_ack_q) begin
                        addr_q  <= cli_address_i[ADDR_WIDTH-1:3];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        cli_data_q <= rd_data_q;
                        cli_ack_q  <= ~cli_ack_q;
                        state_q    <= S_IDLE;
                    end else begin
                        mem_address_q <= {addr_q, 3'b000};
                        mem_req_q     <= ~mem_req_q;
                        flushed_q     <= 1'b0;
                        state_q       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (mem_ack_i == mem_req_q) begin
                        cli_data_q <= mem_data_i;
                        cli_ack_q  <= ~cli_ack_q;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic [15:0] w_hit_base;
    logic [15:0] w_miss_base;
    logic        w_lookup;

    // A flush restarts the statistics; a lookup resolving in that cycle still counts.
    assign w_hit_base  = flush_i ? 16'h0000 : hit_cnt_q;
    assign w_miss_base = flush_i ? 16'h0000 : miss_cnt_q;
    assign w_lookup    = (state_q == S_LOOKUP);

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

    // Saturating hit/miss counters, one increment per lookup resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            hit_cnt_q  <= (w_lookup && w_hit && (w_hit_base != 16'hFFFF))
                          ? w_hit_base + 16'd1 : w_hit_base;
            miss_cnt_q <= (w_lookup && !w_hit && (w_miss_base != 16'hFFFF))
                          ? w_miss_base + 16'd1 : w_miss_base;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tc0480scp_rom_cache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tc0480scp_rom_cache
// Description : Scoreboard bench for tc0480scp_rom_cache with a toggle-handshake
//               ROM model. Statistics checks need TC0480SCP_ROM_CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc0480scp_rom_cache;

    localparam int AW      = 23;
    localparam int MEM_LAT = 4;

    typedef struct {
        logic [63:0] data;
        bit          hit;
        int          t0;
        int          mreq0;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] cli_address = '0;
    logic          cli_req = 1'b0;
    logic          cli_ack_o;
    logic [63:0]   cli_data_o;
    logic          flush = 1'b0;
    logic [AW-1:0] mem_address_o;
    logic          mem_req_o;
    logic          mem_ack = 1'b0;
    logic [63:0]   mem_data = '0;
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
    logic [15:0]   hit_count_o;
    logic [15:0]   miss_count_o;
`endif

    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    int            mem_reqs = 0;
    int            flush_cyc = -1;
    bit            flush_in_fill = 1'b0;
    bit            flush_on_resp = 1'b0;
    exp_t          sb_q[$];
    logic [AW-1:0] maddr_q[$];

    tc0480scp_rom_cache #(.LINE_BITS(6), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cli_address_i (cli_address),
        .cli_req_i     (cli_req),
        .cli_ack_o     (cli_ack_o),
        .cli_data_o    (cli_data_o),
        .flush_i       (flush),
        .mem_address_o (mem_address_o),
        .mem_req_o     (mem_req_o),
        .mem_ack_i     (mem_ack),
        .mem_data_i    (mem_data)
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        ,
        .hit_count_o   (hit_count_o),
        .miss_count_o  (miss_count_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: one hand-picked word, everything else derived from the address.
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        if (a == 23'h000100) return 64'h0123456789ABCDEF;
        return {8'hC3, 1'b0, a, 9'h000, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // ROM model, also the only driver of flush.
    initial begin
        bit            busy;
        int            cnt;
        logic [AW-1:0] la;
        busy = 1'b0;
        cnt  = 0;
        la   = '0;
        forever begin
            @(negedge clk);
            flush = 1'b0;
            if (reset) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    mem_data = mem_word(la);
                    mem_ack  = ~mem_ack;
                    busy     = 1'b0;
                    if (flush_on_resp) flush = 1'b1;
                end else if (flush_in_fill && cnt == 2) begin
                    flush = 1'b1;
                end
            end else if (mem_req_o != mem_ack) begin
                busy = 1'b1;
                cnt  = MEM_LAT;
                la   = mem_address_o;
                mem_reqs++;
                if (maddr_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_mem_req: got address %h, required no request", mem_address_o);
                end else begin
                    chk("mem_address", 64'(mem_address_o), 64'(maddr_q.pop_front()));
                end
            end
            if (cyc == flush_cyc) flush = 1'b1;
        end
    end

    // Monitor: every client ack toggle is matched against the scoreboard head.
    initial begin
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ack = cli_ack_o;
            end else if (cli_ack_o !== prev_ack) begin
                prev_ack = cli_ack_o;
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ack: got ack %b, required no ack", cli_ack_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("cli_data", cli_data_o, e.data);
                    if (e.hit) begin
                        chk("hit_latency", 64'(cyc - e.t0), 64'd2);
                        chk("hit_no_mem_req", 64'(mem_reqs), 64'(e.mreq0));
                    end else begin
                        chk("miss_one_mem_req", 64'(mem_reqs), 64'(e.mreq0 + 1));
                    end
                end
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] a, input bit hit, input bit lk_flush);
        exp_t e;
        bit   done;
        @(negedge clk);
        e.data  = mem_word({a[AW-1:3], 3'b000});
        e.hit   = hit;
        e.t0    = cyc;
        e.mreq0 = mem_reqs;
        sb_q.push_back(e);
        if (!hit) maddr_q.push_back({a[AW-1:3], 3'b000});
        if (lk_flush) flush_cyc = cyc + 1;
        cli_address = a;
        cli_req     = ~cli_req;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (cli_ack_o == cli_req) done = 1'b1;
        end
        if (!done) begin
            checks++;
            $display("FAIL ack_timeout: addr %h got no ack, required ack within 100 cycles", a);
        end
    endtask

    // Watchdog against a hung handshake.
    initial begin
        #(64'd20_000_000);
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_cli_ack", 64'(cli_ack_o), 64'd0);
        chk("reset_mem_req", 64'(mem_req_o), 64'd0);
        chk("reset_cli_data", cli_data_o, 64'd0);
        chk("reset_mem_address", 64'(mem_address_o), 64'd0);

        // Cold miss, then a hit on the same word through a different byte offset.
        do_read(23'h000100, 1'b0, 1'b0);
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        chk("miss_count_t1", 64'(miss_count_o), 64'd1);
`endif
        do_read(23'h000104, 1'b1, 1'b0);
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        chk("hit_count_t2", 64'(hit_count_o), 64'd1);
`endif

        // Same index, different tag: mutual eviction.
        do_read(23'h000300, 1'b0, 1'b0);
        do_read(23'h000100, 1'b0, 1'b0);
        do_read(23'h000300, 1'b0, 1'b0);

        // Neighbouring index; low address bits ignored.
        do_read(23'h000108, 1'b0, 1'b0);
        do_read(23'h00010F, 1'b1, 1'b0);

        // Flush during fill: data returned, line not kept.
        flush_in_fill = 1'b1;
        do_read(23'h000200, 1'b0, 1'b0);
        flush_in_fill = 1'b0;
        do_read(23'h000200, 1'b0, 1'b0);
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        chk("hit_count_t4", 64'(hit_count_o), 64'd0);
        chk("miss_count_t4", 64'(miss_count_o), 64'd1);
`endif
        do_read(23'h000108, 1'b0, 1'b0);
        do_read(23'h000200, 1'b1, 1'b0);

        // Flush coincident with fill completion.
        flush_on_resp = 1'b1;
        do_read(23'h000208, 1'b0, 1'b0);
        flush_on_resp = 1'b0;
        do_read(23'h000208, 1'b0, 1'b0);
        do_read(23'h000208, 1'b1, 1'b0);

        // Flush in the lookup cycle turns a would-be hit into a miss.
        do_read(23'h000208, 1'b0, 1'b1);
        do_read(23'h000208, 1'b1, 1'b0);

        // Reset while a fill is in flight.
        @(negedge clk);
        m0 = mem_reqs;
        maddr_q.push_back(23'h000500);
        cli_address = 23'h000500;
        cli_req     = ~cli_req;
        for (int i = 0; i < 20 && mem_reqs == m0; i++) @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        cli_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_fill_cli_ack", 64'(cli_ack_o), 64'd0);
        chk("rst_fill_mem_req", 64'(mem_req_o), 64'd0);
        do_read(23'h000500, 1'b0, 1'b0);
        do_read(23'h000500, 1'b1, 1'b0);

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        chk("hit_count_rst", 64'(hit_count_o), 64'd1);
        chk("miss_count_rst", 64'(miss_count_o), 64'd1);
        for (int i = 0; i < 70000; i++) do_read(23'h000500, 1'b1, 1'b0);
        chk("hit_count_sat", 64'(hit_count_o), 64'hFFFF);
        chk("miss_count_sat", 64'(miss_count_o), 64'd1);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("mem_expect_drained", 64'(maddr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
